// File: rtl/multiexp_pnt_scl_feeder.sv
// Loads N (point, scalar) pairs once into local RAM, then replays the whole set
// DAT_BITS times on the output stream through a 2-entry skid buffer.
module multiexp_pnt_scl_feeder #(
  parameter int  DAT_BITS = 256,
  parameter int  PNT_BITS = 768,
  parameter int  MAX_IN   = 64,
  parameter int  CTL_BITS = 8,
  localparam int W        = PNT_BITS + DAT_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [63:0]         i_num_in,
  input  logic [W-1:0]        i_load_dat,
  input  logic                i_load_val,
  input  logic                i_load_sop,
  input  logic                i_load_eop,
  output logic                o_load_rdy,
  output logic [W-1:0]        o_pnt_scl_dat,
  output logic                o_pnt_scl_val,
  output logic                o_pnt_scl_sop,
  output logic                o_pnt_scl_eop,
  output logic [CTL_BITS-1:0] o_pnt_scl_ctl,
  input  logic                i_pnt_scl_rdy,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int NW = $clog2(MAX_IN + 1);
  localparam int AW = $clog2(MAX_IN);
  localparam int PW = $clog2(DAT_BITS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REPLAY, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0]        dat;
    logic                sop;
    logic                eop;
    logic                last;
    logic [CTL_BITS-1:0] ctl;
  } ent_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic [NW-1:0] n_q, wr_idx_q;
  logic [AW-1:0] f_i_q;
  logic [PW-1:0] f_p_q;
  logic          f_done_q;

  logic [W-1:0]  ram [MAX_IN];
  logic [W-1:0]  rd_dat_q;
  logic          rd_vld_q, rd_sop_q, rd_eop_q, rd_last_q;
  logic [CTL_BITS-1:0] rd_ctl_q;

  ent_t out_q, skid_q, in_e;
  logic out_val_q, skid_val_q;

  logic start_ok, load_fire, load_last, load_short, pop, last_acc, issue;
  logic f_last_i;
  logic [1:0] occ;
  logic unused_load_sop;

  assign unused_load_sop = i_load_sop;

  assign start_ok   = i_start && (i_num_in != 64'd0) && (i_num_in <= 64'(MAX_IN));
  assign load_fire  = o_load_rdy && i_load_val;
  assign load_last  = load_fire && ((wr_idx_q + NW'(1)) == n_q);
  assign load_short = load_fire && i_load_eop && !load_last;
  assign pop        = out_val_q && i_pnt_scl_rdy;
  assign last_acc   = pop && out_q.last;
  assign f_last_i   = (NW'(f_i_q) == (n_q - NW'(1)));

  // Occupancy counts the RAM read in flight so the landing beat always has a slot.
  assign occ   = {1'b0, out_val_q} + {1'b0, skid_val_q} + {1'b0, rd_vld_q};
  assign issue = (state_q == S_REPLAY) && !f_done_q && ((occ - {1'b0, pop}) < 2'd2);

  assign in_e = {rd_dat_q, rd_sop_q, rd_eop_q, rd_last_q, rd_ctl_q};

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok)     state_d = S_LOAD;
        else if (i_start) err_d   = 1'b1;
      end
      S_LOAD: begin
        if (load_last || load_short) state_d = S_REPLAY;
        err_d = load_short;
      end
      S_REPLAY: if (last_acc) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      n_q      <= '0;
      wr_idx_q <= '0;
      f_i_q    <= '0;
      f_p_q    <= '0;
      f_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && start_ok) begin
        n_q      <= NW'(i_num_in);
        wr_idx_q <= '0;
      end
      if (load_fire)  wr_idx_q <= wr_idx_q + NW'(1);
      if (load_short) n_q      <= wr_idx_q + NW'(1);
      if (state_q == S_LOAD) begin
        f_i_q    <= '0;
        f_p_q    <= '0;
        f_done_q <= 1'b0;
      end else if (issue) begin
        if (f_last_i) begin
          f_i_q <= '0;
          f_p_q <= f_p_q + PW'(1);
          if (f_p_q == PW'(DAT_BITS - 1)) f_done_q <= 1'b1;
        end else begin
          f_i_q <= f_i_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (load_fire) ram[wr_idx_q[AW-1:0]] <= i_load_dat;
    if (issue)     rd_dat_q <= ram[f_i_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_ctl_q   <= '0;
      out_q      <= '0;
      skid_q     <= '0;
      out_val_q  <= 1'b0;
      skid_val_q <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      if (issue) begin
        rd_sop_q  <= (f_i_q == '0);
        rd_eop_q  <= f_last_i;
        rd_last_q <= f_last_i && (f_p_q == PW'(DAT_BITS - 1));
        rd_ctl_q  <= CTL_BITS'(f_i_q);
      end
      // Held output stays put; otherwise refill from skid first, then the RAM beat.
      if (out_val_q && !pop) begin
        if (!skid_val_q && rd_vld_q) begin
          skid_q     <= in_e;
          skid_val_q <= 1'b1;
        end
      end else if (skid_val_q) begin
        out_q      <= skid_q;
        out_val_q  <= 1'b1;
        skid_val_q <= rd_vld_q;
        if (rd_vld_q) skid_q <= in_e;
      end else begin
        out_val_q <= rd_vld_q;
        if (rd_vld_q) out_q <= in_e;
      end
    end
  end

  assign o_load_rdy    = (state_q == S_LOAD);
  assign o_busy        = (state_q == S_LOAD) || (state_q == S_REPLAY);
  assign o_done        = (state_q == S_DONE);
  assign o_err         = err_q;
  assign o_pnt_scl_val = out_val_q;
  assign o_pnt_scl_dat = out_q.dat;
  assign o_pnt_scl_sop = out_q.sop;
  assign o_pnt_scl_eop = out_q.eop;
  assign o_pnt_scl_ctl = out_q.ctl;

endmodule

// File: doc/multiexp_pnt_scl_feeder.md
Name: multiexp_pnt_scl_feeder

Overview:
- Source-side sequencer for the multiexp core's point/scalar input stream.
- Loads N (point, scalar) pairs once over an AXI stream into local RAM.
- Replays the full set DAT_BITS times (one pass per scalar bit) on a second AXI stream, producing exactly the beat sequence the multiexp core consumes.
- Removes the need for host/DMA to re-send the same data DAT_BITS times.

Parameters:
- DAT_BITS, 256, scalar (fe_t) width; also the number of replay passes.
- PNT_BITS, 768, Jacobian point (jb_point_t) width.
- MAX_IN, 64, RAM depth; maximum pairs per job.
- CTL_BITS, 8, ctl field width on both streams.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  one-cycle pulse; latches i_num_in, begins LOAD; ignored unless IDLE
- i_num_in  input  64  number of pairs N for this job
- i_load_if  if_axi_stream slave  DAT=PNT_BITS+DAT_BITS  load stream; dat={point,scalar}; uses val, rdy, sop, eop
- o_pnt_scl_if  if_axi_stream master  DAT=PNT_BITS+DAT_BITS  replay stream; dat={point,scalar}; uses val, rdy, sop, eop, ctl
- o_busy  output  1  high in LOAD or REPLAY
- o_done  output  1  one-cycle pulse after last replay beat accepted
- o_err  output  1  one-cycle pulse on rejected start or short load

Behaviour:
- Reset values (async assert, sync deassert): state IDLE; o_pnt_scl_if.val=0, sop=0, eop=0, ctl=0, dat=0; i_load_if.rdy=0; o_busy=0; o_done=0; o_err=0; all counters 0.
- States: IDLE, LOAD, REPLAY, DONE.
- IDLE:
  - i_start with 1<=i_num_in<=MAX_IN: latch N, go to LOAD.
  - i_start with i_num_in=0 or i_num_in>MAX_IN: pulse o_err, stay IDLE.
- LOAD:
  - i_load_if.rdy=1.
  - Each val&rdy beat writes RAM[wr_idx], wr_idx++.
  - After the N-th beat: rdy drops the next cycle; go to REPLAY. Any eop on that beat is ignored.
  - Early eop (beat count < N): store the beat, set N = count, pulse o_err, go to REPLAY.
  - Beats beyond N are never accepted.
- REPLAY:
  - Emits N×DAT_BITS beats, ordered pass p=0..DAT_BITS-1, index i=0..N-1.
  - Each beat: dat=RAM[i], ctl=i[CTL_BITS-1:0], sop=(i==0), eop=(i==N-1). N=1 gives sop=eop=1 on every beat.
  - RAM read latency is 1 cycle. Output is registered with a 2-entry skid buffer: sustains 1 beat/cycle while rdy=1, and dat/sop/eop/ctl hold stable while val&!rdy.
  - First val asserts no later than 2 cycles after entering REPLAY.
  - Counters i and p advance only on accepted beats.
  - i wraps N-1→0 with p++.
  - Beat (p=DAT_BITS-1, i=N-1) accepted → DONE.
- DONE: o_done=1 for one cycle, then IDLE. RAM contents are retained but not reused; every job requires a new load.
- i_start during LOAD/REPLAY/DONE: ignored, no o_err.
- rdy low for arbitrary cycles mid-pass or across a pass boundary: no beat lost or duplicated.
- Reset mid-LOAD or mid-REPLAY: immediate return to IDLE with val low; partial job discarded; next job requires i_start.
- Throughput: with rdy held high, REPLAY lasts N×DAT_BITS+2 cycles or fewer.

Test Plan:
- Basic: N=8, load 8 random pairs, rdy always 1 → 2048 beats; beat k carries RAM[k mod 8], sop on k mod 8=0, eop on k mod 8=7, ctl=k mod 8; o_done exactly once; total replay cycles ≤2050.
- Back-pressure: N=3, random 50% rdy on output and random load val gaps → 768 beats, order identical to Basic pattern; dat stable on every stalled cycle (assertion).
- Boundaries: N=1 → 256 beats, all sop=eop=1. N=MAX_IN=64 → 16384 beats. i_num_in=0 and i_num_in=65 → o_err pulse, o_busy stays 0.
- Short load: i_num_in=5, eop on 3rd beat → o_err pulse; replay N=3 (768 beats); load rdy=0 after the 3rd beat.
- Reset mid-REPLAY: assert i_rst_n=0 at pass 100 → val=0 in the same cycle; after release, new job N=2 replays correctly from p=0, i=0.
- End-to-end: feed output into multiexp_top with N=8 random Jacobian points/scalars → result equals software multiexp_batch in affine form.
